// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB fade/PWM output stage.
//   state_t      - fade controller states (ST_IDLE, ST_FADE)
//   CH_R/G/B     - channel indices into per-channel vectors in the top level
//   gamma_map()  - squared-brightness map, (cur*cur + 2^bits-1) >> bits,
//                  valid for bits <= 16; preserves 0, 1 and full scale.
package rgb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  function automatic logic [15:0] gamma_map(input logic [15:0] cur,
                                            input int unsigned bits);
    logic [31:0] sq;
    // Rounding up by 2^bits-1 keeps 1 -> 1 and full scale -> full scale.
    sq = ({16'b0, cur} * {16'b0, cur}) + ((32'd1 << bits) - 32'd1);
    return 16'(sq >> bits);
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One colour channel of the RGB output stage.
// Holds the target and current intensity, steps the current value one LSB
// toward the target on each step tick, maps it to a duty (optionally through
// the gamma curve when RGB_GAMMA_EN is defined), shadows the duty at PWM
// period boundaries and drives a registered active-low LED pin.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - capture target_in as the new target
//   step        - move current value one LSB toward the target
//   target_in   - requested intensity
//   pwm_cnt     - shared free-running PWM counter
//   at_target   - current value equals target
//   led         - PWM output, 0 = lit
module rgb_pwm_channel
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [PWM_BITS-1:0] target_in,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                at_target,
  output logic                led
);

  logic [PWM_BITS-1:0] target_q;
  logic [PWM_BITS-1:0] cur_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] mapped;
  logic                led_q;

`ifdef RGB_GAMMA_EN
  assign mapped = PWM_BITS'(gamma_map(16'(cur_q), PWM_BITS));
`else
  assign mapped = cur_q;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      cur_q    <= '0;
      duty_q   <= '0;
      led_q    <= 1'b1;
    end else begin
      if (load) begin
        target_q <= target_in;
      end
      // The channel stops at its target, so the range ends are never crossed.
      if (step) begin
        if (cur_q < target_q) begin
          cur_q <= cur_q + PWM_BITS'(1);
        end else if (cur_q > target_q) begin
          cur_q <= cur_q - PWM_BITS'(1);
        end
      end
      // Duty only changes as the counter wraps, so no period is ever split.
      if (pwm_cnt == '1) begin
        duty_q <= mapped;
      end
      led_q <= ~(pwm_cnt < duty_q);
    end
  end

  assign at_target = (cur_q == target_q);
  assign led       = led_q;

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB LED output stage: accepts 8-bit-per-channel colour targets on a
// valid/ready handshake, fades each channel linearly one LSB per FADE_DIV
// cycles toward its target and renders it as glitch-free active-low PWM.
// Optional build macro: RGB_GAMMA_EN (gamma-mapped duty instead of linear).
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   color_valid / color_ready   - target handshake (ready only while idle)
//   color_r / color_g / color_b - target intensity per channel, 0 = off
//   fade_busy                   - a fade is in progress
//   LED_R / LED_G / LED_B       - registered PWM pins, 0 = lit
module rgb_fade_pwm
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                color_valid,
  output logic                color_ready,
  input  logic [PWM_BITS-1:0] color_r,
  input  logic [PWM_BITS-1:0] color_g,
  input  logic [PWM_BITS-1:0] color_b,
  output logic                fade_busy,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B
);

  localparam int               TMR_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(FADE_DIV - 1);

  state_t              state_q;
  state_t              state_d;
  logic [TMR_W-1:0]    tmr_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                accept;
  logic                step;
  logic [2:0]          at_target;
  logic [2:0]          led;

  assign accept = color_valid & color_ready;
  assign step   = (state_q == ST_FADE) && (tmr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    color_ready = 1'b0;
    fade_busy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        color_ready = 1'b1;
        if (color_valid) begin
          state_d = ST_FADE;
        end
      end
      ST_FADE: begin
        fade_busy = 1'b1;
        if (&at_target) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Step timer: counts FADE_DIV cycles per step, first step FADE_DIV cycles
  // after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (accept) begin
      tmr_q <= TMR_RELOAD;
    end else if (state_q == ST_FADE) begin
      if (tmr_q == '0) begin
        tmr_q <= TMR_RELOAD;
      end else begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step),
    .target_in (color_r),
    .pwm_cnt   (pwm_cnt),
    .at_target (at_target[CH_R]),
    .led       (led[CH_R])
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step),
    .target_in (color_g),
    .pwm_cnt   (pwm_cnt),
    .at_target (at_target[CH_G]),
    .led       (led[CH_G])
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step),
    .target_in (color_b),
    .pwm_cnt   (pwm_cnt),
    .at_target (at_target[CH_B]),
    .led       (led[CH_B])
  );

  assign LED_R = led[CH_R];
  assign LED_G = led[CH_G];
  assign LED_B = led[CH_B];

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Self-checking bench for rgb_fade_pwm with PWM_BITS = 8, FADE_DIV = 4.
// Expected duties follow the gamma curve when RGB_GAMMA_EN is defined.
module tb_rgb_fade_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       color_valid;
  logic       color_ready;
  logic [7:0] color_r;
  logic [7:0] color_g;
  logic [7:0] color_b;
  logic       fade_busy;
  logic       LED_R;
  logic       LED_G;
  logic       LED_B;

  int checks   = 0;
  int failures = 0;
  int duty_viol = 0;

  rgb_fade_pwm #(.PWM_BITS(8), .FADE_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .color_r     (color_r),
    .color_g     (color_g),
    .color_b     (color_b),
    .fade_busy   (fade_busy),
    .LED_R       (LED_R),
    .LED_G       (LED_G),
    .LED_B       (LED_B)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int r;
    int b;
    int busy;
    int ready;
  } fade_vec_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         er;
    int         eg;
    int         eb;
  } duty_vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    color_r     = r;
    color_g     = g;
    color_b     = b;
    color_valid = 1'b1;
    tick();
    color_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (fade_busy && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(fade_busy), 0);
  endtask

  task automatic count_lit(output int nr, output int ng, output int nb);
    nr = 0;
    ng = 0;
    nb = 0;
    repeat (520) tick();
    for (int i = 0; i < 256; i++) begin
      tick();
      if (!LED_R) nr++;
      if (!LED_G) ng++;
      if (!LED_B) nb++;
    end
  endtask

  // Duty registers may only change on the edge that wraps the PWM counter.
  logic [7:0] prev_cnt;
  logic [7:0] prev_dr;
  logic [7:0] prev_dg;
  logic [7:0] prev_db;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && prev_cnt != 8'hFF &&
        (dut.u_ch_r.duty_q != prev_dr || dut.u_ch_g.duty_q != prev_dg ||
         dut.u_ch_b.duty_q != prev_db)) begin
      duty_viol++;
    end
    prev_cnt = dut.pwm_cnt;
    prev_dr  = dut.u_ch_r.duty_q;
    prev_dg  = dut.u_ch_g.duty_q;
    prev_db  = dut.u_ch_b.duty_q;
  end

  fade_vec_t fv[6];
  duty_vec_t dv[2];

  initial begin
    int cyc;
    int bad;
    int nr, ng, nb;
    int n;

    fv[0] = '{cyc: 0,  r: 0, b: 0, busy: 1, ready: 0};
    fv[1] = '{cyc: 3,  r: 0, b: 0, busy: 1, ready: 0};
    fv[2] = '{cyc: 4,  r: 1, b: 1, busy: 1, ready: 0};
    fv[3] = '{cyc: 8,  r: 2, b: 1, busy: 1, ready: 0};
    fv[4] = '{cyc: 12, r: 3, b: 1, busy: 1, ready: 0};
    fv[5] = '{cyc: 13, r: 3, b: 1, busy: 0, ready: 1};

`ifdef RGB_GAMMA_EN
    dv[0] = '{r: 8'd64,  g: 8'd255, b: 8'd0,   er: 16, eg: 255, eb: 0};
    dv[1] = '{r: 8'd128, g: 8'd1,   b: 8'd255, er: 64, eg: 1,   eb: 255};
`else
    dv[0] = '{r: 8'd64,  g: 8'd255, b: 8'd0,   er: 64,  eg: 255, eb: 0};
    dv[1] = '{r: 8'd128, g: 8'd1,   b: 8'd255, er: 128, eg: 1,   eb: 255};
`endif

    rst_n       = 1'b0;
    color_valid = 1'b0;
    color_r     = 8'd0;
    color_g     = 8'd0;
    color_b     = 8'd0;

    // Reset values.
    repeat (3) tick();
    check("rst_led_r", int'(LED_R), 1);
    check("rst_led_g", int'(LED_G), 1);
    check("rst_led_b", int'(LED_B), 1);
    check("rst_ready", int'(color_ready), 1);
    check("rst_busy", int'(fade_busy), 0);
    check("rst_pwm_cnt", int'(dut.pwm_cnt), 0);

    // After release with no command the pins stay dark.
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!LED_R || !LED_G || !LED_B || fade_busy) bad++;
    end
    check("idle_dark", bad, 0);

    // Fade timing: (3,0,1) from black.
    accept(8'd3, 8'd0, 8'd1);
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      while (cyc < fv[k].cyc) begin
        tick();
        cyc++;
      end
      check($sformatf("fade_r@%0d", fv[k].cyc), int'(dut.u_ch_r.cur_q), fv[k].r);
      check($sformatf("fade_b@%0d", fv[k].cyc), int'(dut.u_ch_b.cur_q), fv[k].b);
      check($sformatf("busy@%0d", fv[k].cyc), int'(fade_busy), fv[k].busy);
      check($sformatf("ready@%0d", fv[k].cyc), int'(color_ready), fv[k].ready);
    end

    // Duty per period.
    for (int k = 0; k < 2; k++) begin
      accept(dv[k].r, dv[k].g, dv[k].b);
      wait_idle($sformatf("duty%0d_fade_done", k), 2000);
      count_lit(nr, ng, nb);
      check($sformatf("duty%0d_lit_r", k), nr, dv[k].er);
      check($sformatf("duty%0d_lit_g", k), ng, dv[k].eg);
      check($sformatf("duty%0d_lit_b", k), nb, dv[k].eb);
    end

    // Handshake: valid during a fade is ignored, then taken on the first
    // idle cycle while still held.
    accept(8'd10, 8'd10, 8'd10);
    repeat (20) tick();
    color_r     = 8'd0;
    color_g     = 8'd0;
    color_b     = 8'd200;
    color_valid = 1'b1;
    repeat (10) tick();
    check("hs_ready_low", int'(color_ready), 0);
    check("hs_busy_high", int'(fade_busy), 1);
    check("hs_target_b_kept", int'(dut.u_ch_b.target_q), 10);
    n = 0;
    while (!color_ready && n < 2000) begin
      tick();
      n++;
    end
    check("hs_ready_back", int'(color_ready), 1);
    check("hs_first_fade_r", int'(dut.u_ch_r.cur_q), 10);
    check("hs_first_fade_b", int'(dut.u_ch_b.cur_q), 10);
    tick();
    color_valid = 1'b0;
    check("hs_held_accepted", int'(fade_busy), 1);
    check("hs_new_target_b", int'(dut.u_ch_b.target_q), 200);
    wait_idle("hs_second_fade_done", 2000);
    check("hs_cur_b", int'(dut.u_ch_b.cur_q), 200);
    check("hs_cur_r", int'(dut.u_ch_r.cur_q), 0);

    // Equal target: exactly one busy cycle.
    accept(8'd0, 8'd0, 8'd200);
    check("eq_busy_1st", int'(fade_busy), 1);
    tick();
    check("eq_busy_2nd", int'(fade_busy), 0);
    check("eq_ready_2nd", int'(color_ready), 1);

    // Fade down from (2,2,2) to black without underflow.
    accept(8'd2, 8'd2, 8'd2);
    wait_idle("down_prep_done", 2000);
    accept(8'd0, 8'd0, 8'd0);
    repeat (4) tick();
    check("down_r@4", int'(dut.u_ch_r.cur_q), 1);
    repeat (4) tick();
    check("down_r@8", int'(dut.u_ch_r.cur_q), 0);
    check("down_b@8", int'(dut.u_ch_b.cur_q), 0);
    check("down_busy@8", int'(fade_busy), 1);
    tick();
    check("down_busy@9", int'(fade_busy), 0);
    repeat (8) tick();
    check("down_r_no_wrap", int'(dut.u_ch_r.cur_q), 0);
    check("down_g_no_wrap", int'(dut.u_ch_g.cur_q), 0);

    check("no_mid_period_duty_change", duty_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
